// File: rtl/stream_fetch.sv
// stream_fetch: reads LEN words from a sync-read memory starting at a base
// address and streams them out in order through a 2-entry FIFO.
// Ports: clk, rstn (async, active-high), start_i, base_addr_i,
//   mem_en_o, mem_addr_o, mem_data_i (memory side),
//   m_valid_o, m_data_o, m_last_o, m_ready_i (stream side),
//   busy_o, done_o (start/done handshake).
module stream_fetch #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int LEN    = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  output logic              mem_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  input  logic              m_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam int CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(LEN);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_issue_cnt;
  logic [CNT_W-1:0]  r_acc_cnt;
  logic              r_inflight;
  logic [DATA_W-1:0] r_fifo [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_occ;

  logic       w_run;
  logic       w_pop;
  logic       w_push;
  logic       w_issue;
  logic [2:0] w_credit;
  logic [2:0] w_limit;

  assign w_run  = (r_state == S_RUN);
  assign w_pop  = m_valid_o && m_ready_i;
  assign w_push = w_run && r_inflight;

  // Credit: buffered + returning words must stay below 2 after this
  // cycle's pop, so a new read always has a FIFO slot when it lands.
  assign w_credit = {1'b0, r_occ} + {2'b00, r_inflight};
  assign w_limit  = 3'd2 + {2'b00, w_pop};
  assign w_issue  = w_run && (r_issue_cnt < LEN_C) && (w_credit < w_limit);

  assign mem_en_o   = w_issue;
  assign mem_addr_o = w_run ? r_base + ADDR_W'(r_issue_cnt) : '0;

  assign m_valid_o = w_run && (r_occ != 2'd0);
  assign m_data_o  = r_fifo[r_rptr];
  assign m_last_o  = m_valid_o && (r_acc_cnt == LAST_C);

  assign busy_o = w_run;
  assign done_o = (r_state == S_DONE);

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_issue_cnt <= '0;
      r_acc_cnt   <= '0;
      r_inflight  <= 1'b0;
      r_fifo[0]   <= '0;
      r_fifo[1]   <= '0;
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_occ       <= 2'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state     <= S_RUN;
            r_base      <= base_addr_i;
            r_issue_cnt <= '0;
            r_acc_cnt   <= '0;
            r_inflight  <= 1'b0;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_occ       <= 2'd0;
          end
        end
        S_RUN: begin
          r_inflight <= w_issue;
          if (w_issue)
            r_issue_cnt <= r_issue_cnt + CNT_W'(1);
          if (w_push) begin
            r_fifo[r_wptr] <= mem_data_i;
            r_wptr         <= ~r_wptr;
          end
          if (w_pop) begin
            r_rptr    <= ~r_rptr;
            r_acc_cnt <= r_acc_cnt + CNT_W'(1);
          end
          r_occ <= r_occ + 2'(w_push) - 2'(w_pop);
          if (w_pop && m_last_o)
            r_state <= S_DONE;
        end
        S_DONE: begin
          if (!start_i)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  ap_no_overflow: assert property (
    @(posedge clk) disable iff (rstn)
    !(w_push && !w_pop && r_occ == 2'd2)
  );

endmodule

// File: tb/tb_stream_fetch.sv
// tb_stream_fetch: randomized scoreboard bench for stream_fetch.
// Stimulus pushes expected words; a negedge monitor pops and compares.
module tb_stream_fetch;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int L  = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic          mem_en_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_i;
  logic          m_valid_o;
  logic [DW-1:0] m_data_o;
  logic          m_last_o;
  logic          m_ready_i = 1'b0;
  logic          busy_o;
  logic          done_o;

  logic          b_start = 1'b0;
  logic          b_en;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_rd;
  logic          b_valid;
  logic [DW-1:0] b_data;
  logic          b_last;
  logic          b_busy;
  logic          b_done;

  logic [DW-1:0] mem [16];

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t          exq[$];
  logic [AW-1:0] addrq[$];

  int errs   = 0;
  int checks = 0;
  int hs     = 0;
  bit rnd_mode = 1'b0;

  logic          hold_v = 1'b0;
  logic [DW-1:0] hold_d = '0;
  logic          hold_l = 1'b0;

  always #5 clk = ~clk;

  stream_fetch #(.DATA_W(DW), .ADDR_W(AW), .LEN(L)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start_i    (start_i),
    .base_addr_i(base_addr_i),
    .mem_en_o   (mem_en_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_i (mem_data_i),
    .m_valid_o  (m_valid_o),
    .m_data_o   (m_data_o),
    .m_last_o   (m_last_o),
    .m_ready_i  (m_ready_i),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  stream_fetch #(.DATA_W(DW), .ADDR_W(AW), .LEN(1)) u_len1 (
    .clk        (clk),
    .rstn       (rstn),
    .start_i    (b_start),
    .base_addr_i(4'd7),
    .mem_en_o   (b_en),
    .mem_addr_o (b_addr),
    .mem_data_i (b_rd),
    .m_valid_o  (b_valid),
    .m_data_o   (b_data),
    .m_last_o   (b_last),
    .m_ready_i  (1'b1),
    .busy_o     (b_busy),
    .done_o     (b_done)
  );

  always @(posedge clk) begin
    if (mem_en_o) mem_data_i <= mem[mem_addr_o];
    if (b_en) b_rd <= mem[b_addr];
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: address log, hold-stability and in-order data/last checks.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rstn) begin
      hold_v = 1'b0;
    end else begin
      if (mem_en_o) addrq.push_back(mem_addr_o);
      if (hold_v) begin
        chk("stable_valid", m_valid_o, 1);
        chk("stable_data", m_data_o, hold_d);
        chk("stable_last", m_last_o, hold_l);
      end
      hold_v = m_valid_o && !m_ready_i;
      hold_d = m_data_o;
      hold_l = m_last_o;
      if (m_valid_o && m_ready_i) begin
        hs++;
        if (exq.size() == 0) begin
          chk("extra_word", 1, 0);
        end else begin
          e = exq.pop_front();
          chk("data", m_data_o, e.d);
          chk("last", m_last_o, e.l);
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_mode) m_ready_i = 1'($urandom_range(0, 1));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller is at posedge+1; this cycle becomes cycle 0 of the run.
  task automatic start_run(logic [AW-1:0] b);
    exp_t e;
    base_addr_i = b;
    start_i     = 1'b1;
    hs          = 0;
    addrq.delete();
    for (int i = 0; i < L; i++) begin
      e.d = mem[4'(b + 4'(i))];
      e.l = (i == L - 1);
      exq.push_back(e);
    end
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    while (!done_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", done_o, 1);
    step();
  endtask

  task automatic finish_run();
    chk("handshakes", hs, L);
    chk("queue_drained", exq.size(), 0);
    start_i = 1'b0;
    step();
    step();
    chk("idle_after_drop", {done_o, busy_o}, 2'b00);
  endtask

  initial begin
    int first_v;
    int last_c;
    int nlast;
    int b1_v;
    int b1_iss;

    for (int i = 0; i < 16; i++) mem[i] = 8'(i + 16);

    @(negedge clk);
    chk("rst_mem_en", mem_en_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_valid", m_valid_o, 0);
    chk("rst_data", m_data_o, 0);
    chk("rst_last", m_last_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    step();
    rstn = 1'b0;
    step();

    // Nominal run with cycle-exact timing.
    m_ready_i = 1'b1;
    start_run(4'd0);
    first_v = -1;
    last_c  = -1;
    nlast   = 0;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      if (m_valid_o && first_v < 0) first_v = c;
      if (m_last_o) begin
        last_c = c;
        nlast++;
      end
      if (c == 1) chk("first_addr", {mem_en_o, mem_addr_o}, {1'b1, 4'd0});
      if (c == 19) chk("done_c19", {done_o, busy_o}, 2'b10);
    end
    chk("first_valid_cycle", first_v, 3);
    chk("last_cycle", last_c, 18);
    chk("last_count", nlast, 1);
    chk("nom_issues", addrq.size(), L);
    chk("nom_handshakes", hs, L);
    repeat (5) @(negedge clk);
    chk("held_start_done", {done_o, busy_o, mem_en_o}, 3'b100);
    step();
    start_i = 1'b0;
    step();
    chk("drop_to_idle", {done_o, busy_o}, 2'b00);

    // Address wrap with fresh random memory.
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    start_run(4'hC);
    wait_done(200);
    chk("wrap_issues", addrq.size(), L);
    for (int i = 0; i < L && i < addrq.size(); i++)
      chk("wrap_addr", addrq[i], 4'(4'hC + 4'(i)));
    finish_run();

    // Backpressure from cycle 2.
    start_run(4'd5);
    step();
    step();
    m_ready_i = 1'b0;
    repeat (6) step();
    @(negedge clk);
    chk("bp_valid", m_valid_o, 1);
    chk("bp_no_issue", mem_en_o, 0);
    chk("bp_issues", addrq.size(), 2);
    chk("bp_head", m_data_o, mem[5]);
    step();
    m_ready_i = 1'b1;
    wait_done(200);
    finish_run();

    // Random ready toggling.
    for (int r = 0; r < 4; r++) begin
      start_run(4'($urandom_range(0, 15)));
      rnd_mode = 1'b1;
      wait_done(800);
      rnd_mode  = 1'b0;
      m_ready_i = 1'b1;
      finish_run();
    end

    // Reset in cycle 6 of a run, then a clean run.
    start_run(4'd3);
    repeat (6) step();
    rstn    = 1'b1;
    start_i = 1'b0;
    exq.delete();
    @(negedge clk);
    chk("mr_outputs",
        {mem_en_o, mem_addr_o, m_valid_o, m_data_o, m_last_o, busy_o, done_o},
        '0);
    step();
    rstn = 1'b0;
    step();
    start_run(4'd9);
    wait_done(200);
    finish_run();

    // LEN = 1 instance.
    b1_v   = -1;
    b1_iss = 0;
    b_start = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (b_en) b1_iss++;
      if (b_valid && b1_v < 0) begin
        b1_v = c;
        chk("len1_data", {b_last, b_data}, {1'b1, mem[7]});
      end
      if (c == 4) chk("len1_done_c4", {b_done, b_busy}, 2'b10);
    end
    chk("len1_valid_cycle", b1_v, 3);
    chk("len1_issues", b1_iss, 1);
    step();
    b_start = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/stream_fetch.md
# stream_fetch

Upstream feeder for the streamline controller datapath. On a start request it reads LEN consecutive words from a synchronous-read memory, beginning at a programmable base address. It delivers the words in order on a valid/ready stream, buffering them in a 2-entry FIFO, and reports completion on done_o using the same start/done handshake as the controller top level.

## Interface
- DATA_W, 8, width of memory words and stream data
- ADDR_W, 4, memory address width
- LEN, 16, words fetched per run (1 ≤ LEN ≤ 2^ADDR_W)
- clk  in  1  clock, all state updates on rising edge
- rstn  in  1  reset, asynchronous, active-high
- start_i  in  1  run request, level; sampled only in IDLE
- base_addr_i  in  ADDR_W  first read address; captured when start is accepted
- mem_en_o  out  1  memory read enable (combinational)
- mem_addr_o  out  ADDR_W  memory read address (combinational)
- mem_data_i  in  DATA_W  read data, valid exactly 1 cycle after mem_en_o
- m_valid_o  out  1  stream data valid (FIFO non-empty)
- m_data_o  out  DATA_W  stream data (FIFO head)
- m_last_o  out  1  high with the LEN-th word
- m_ready_i  in  1  downstream accept
- busy_o  out  1  high in RUN
- done_o  out  1  high in DONE

## Operation
- States: IDLE, RUN and DONE.
- IDLE → RUN: when start_i = 1 at a clock edge. The same edge captures base_addr_i and clears issue_cnt, acc_cnt, the in-flight flag and the FIFO.
- RUN → DONE: at the edge where the word with m_last_o = 1 handshakes (m_valid_o & m_ready_i).
- DONE → IDLE: at the first edge with start_i = 0. done_o stays high while start_i is held high, so a held start never retriggers a run.
- Read issue in RUN: mem_en_o = (issue_cnt < LEN) & (occ + inflight − pop < 2).
  - occ is FIFO occupancy (0..2).
  - inflight is 1 if a read was issued in the previous cycle.
  - pop = m_valid_o & m_ready_i, which makes this path combinational from m_ready_i.
- mem_addr_o = base + issue_cnt, truncated to ADDR_W bits, so the address wraps modulo 2^ADDR_W.
- issue_cnt increments on each issued read.
- A read returning (inflight = 1) pushes mem_data_i into the FIFO at that edge. A push and a pop in the same cycle are both honoured.
- The credit rule guarantees the FIFO never overflows. Overflow is an assertion failure.
- m_last_o = m_valid_o & (acc_cnt == LEN−1). acc_cnt increments on each pop.
- While m_valid_o & !m_ready_i, m_data_o and m_last_o hold stable.
- Outside RUN: mem_en_o = 0 and m_valid_o = 0. The FIFO is always empty on leaving RUN.

## Timing
- Reset values: state IDLE; mem_en_o 0; mem_addr_o 0; m_valid_o 0; m_data_o 0; m_last_o 0; busy_o 0; done_o 0; counters, inflight and FIFO cleared.
- Reset mid-run: returns to IDLE immediately. Any in-flight read data is discarded.
- Start sampled at edge E0 (end of cycle 0):
  - Cycle 1: first mem_en_o, with mem_addr_o = base.
  - Cycle 2: data returns and is pushed at the end of the cycle.
  - Cycle 3: first m_valid_o.
- Throughput with m_ready_i held high: 1 word/cycle.
  - LEN = 16: words appear in cycles 3..18, with m_last_o in cycle 18.
  - Cycle 19: done_o = 1 and busy_o = 0.
- LEN = 1: one read is issued. m_last_o is high with the first word in cycle 3, and done_o is high in cycle 4.
- With m_ready_i low: at most 2 reads are outstanding or buffered, after which mem_en_o stays 0 until a pop occurs.

## Test plan
- Reset mid-run → assert rstn in cycle 6 of a run → all outputs 0 next cycle; a new start gives a clean run from the captured base with no stale word.
- Nominal run → base = 0, memory[i] = i+0x10, start held high, m_ready_i = 1 → words 0x10..0x1F in cycles 3..18; m_last_o only on 0x1F; done_o rises in cycle 19 and stays high.
- Address wrap → base = 0xC, LEN = 16 → mem_addr_o sequence C,D,E,F,0,1,…,B; data order matches.
- Backpressure → m_ready_i low from cycle 2 → FIFO holds 2 words, mem_en_o is 0 after the 2nd issue, m_data_o stays stable; release → remaining words arrive in order with no loss or duplication.
- Random ready toggling (seeded) → exactly LEN handshakes; m_last_o only on the final one; no FIFO overflow assertion fires.
- Start held high → done_o stays high, no second run starts; drop start → IDLE next edge; raise start again → a second full run.
